// File: rtl/mini_core_pkg.sv
// rtl/mini_core_pkg.sv - opcode encodings and instruction field helpers for mini_core_param
//
// Purpose: shared opcode values and helper functions that size and locate
// the fields of the parametrised instruction word. An instruction word is
//   [IW-1 -: 4] opcode | dest | src1 | src0   (ADDR_WIDTH bits each, src0 lowest)
// Ports: none (package).

package mini_core_pkg;

  typedef logic [3:0] opcode_t;

  localparam int OPCODE_WIDTH = 4;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_LED  = 4'h1;
  localparam opcode_t OP_BLE  = 4'h2;
  localparam opcode_t OP_STO  = 4'h3;
  localparam opcode_t OP_ADD  = 4'h4;
  localparam opcode_t OP_JMP  = 4'h5;
  localparam opcode_t OP_SUB  = 4'h6;
  localparam opcode_t OP_SMUL = 4'h7;
  localparam opcode_t OP_SHL  = 4'h8;
  localparam opcode_t OP_SHR  = 4'h9;
  localparam opcode_t OP_CALL = 4'hA;
  localparam opcode_t OP_RET  = 4'hB;

  // Lowest bit of the src0 field; the other fields stack above it.
  localparam int SRC0_LSB = 0;

  function automatic int instr_width(input int addr_width);
    return OPCODE_WIDTH + 3 * addr_width;
  endfunction

  function automatic int src1_lsb(input int addr_width);
    return SRC0_LSB + addr_width;
  endfunction

  function automatic int dest_lsb(input int addr_width);
    return SRC0_LSB + 2 * addr_width;
  endfunction

  // Shift amount width; a 1-bit datapath still needs a 1-bit field.
  function automatic int shamt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

  // Index width for an array of 'depth' entries (never zero).
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mini_core_regfile.sv
// rtl/mini_core_regfile.sv - register file, two combinational reads, one synchronous write
//
// Purpose: 2^ADDR_WIDTH x DATA_WIDTH storage for mini_core_param. Contents
// are not reset; a location is undefined until first written.
// Ports:
//   clk        in   write clock (posedge)
//   wr_en      in   write strobe
//   wr_addr    in   write address
//   wr_data    in   write data
//   rd_addr_a  in   read port A address
//   rd_data_a  out  read port A data (combinational)
//   rd_addr_b  in   read port B address
//   rd_data_b  out  read port B data (combinational)

module mini_core_regfile
  import mini_core_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/mini_core_param.sv
// rtl/mini_core_param.sv - two-stage fetch/execute core driving the LED bank
//
// Purpose: fetches one instruction per cycle from an external ROM and
// executes it in the following cycle. Taken branches squash the slot that
// was fetched alongside them. CALL/RET use a bounded return stack; misuse
// of the stack and undefined opcodes raise sticky flags.
// Ports:
//   Clock         in   sole clock, posedge
//   Reset         in   synchronous, active-high
//   oIP           out  fetch address to the instruction memory
//   iInstruction  in   instruction at oIP (combinational, same cycle)
//   oLed          out  LED register
//   oStackError   out  sticky: return-stack overflow or underflow
//   oIllegal      out  sticky: undefined opcode executed

module mini_core_param
  import mini_core_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int IP_WIDTH    = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LED_WIDTH   = 8,
  parameter int SIGNED_CMP  = 0
) (
  input  logic                               Clock,
  input  logic                               Reset,
  output logic [IP_WIDTH-1:0]                oIP,
  input  logic [instr_width(ADDR_WIDTH)-1:0] iInstruction,
  output logic [LED_WIDTH-1:0]               oLed,
  output logic                               oStackError,
  output logic                               oIllegal
);

  localparam int IW  = instr_width(ADDR_WIDTH);
  localparam int SHW = shamt_width(DATA_WIDTH);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = index_width(STACK_DEPTH);

  // Fetch / EX pipeline state
  logic [IP_WIDTH-1:0]   ip_q;
  logic [IW-1:0]         ex_instr_q;
  logic [IP_WIDTH-1:0]   ex_ip_q;

  // Return stack: sp_q counts occupied entries, 0..STACK_DEPTH
  logic [IP_WIDTH-1:0]   stack_mem [STACK_DEPTH];
  logic [SPW-1:0]        sp_q;
  logic [SIW-1:0]        push_idx;
  logic [SIW-1:0]        top_idx;
  logic                  stack_full;
  logic                  stack_empty;

  logic [LED_WIDTH-1:0]  led_q;
  logic                  stack_err_q;
  logic                  illegal_q;

  // Decoded EX fields
  opcode_t               opcode;
  logic [ADDR_WIDTH-1:0] dest;
  logic [ADDR_WIDTH-1:0] src1;
  logic [ADDR_WIDTH-1:0] src0;

  // Operands: A = R[src1], B = R[src0]
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [SHW-1:0]        shamt;
  logic                  a_le_b;

  // Execute controls
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  led_wr;
  logic                  push;
  logic                  pop;
  logic                  branch_taken;
  logic [IP_WIDTH-1:0]   branch_target;
  logic                  set_stack_err;
  logic                  set_illegal;
  logic [IP_WIDTH-1:0]   ret_addr;

  assign opcode = ex_instr_q[IW-1 -: OPCODE_WIDTH];
  assign dest   = ex_instr_q[dest_lsb(ADDR_WIDTH) +: ADDR_WIDTH];
  assign src1   = ex_instr_q[src1_lsb(ADDR_WIDTH) +: ADDR_WIDTH];
  assign src0   = ex_instr_q[SRC0_LSB +: ADDR_WIDTH];

  mini_core_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk       (Clock),
    .wr_en     (wr_en & ~Reset),
    .wr_addr   (dest),
    .wr_data   (wr_data),
    .rd_addr_a (src1),
    .rd_data_a (op_a),
    .rd_addr_b (src0),
    .rd_data_b (op_b)
  );

  assign shamt = op_b[SHW-1:0];
  assign a_le_b = (SIGNED_CMP != 0) ? ($signed(op_a) <= $signed(op_b))
                                    : (op_a <= op_b);

  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  // Only used when not full / not empty, so both indices stay in range.
  assign push_idx    = SIW'(sp_q);
  assign top_idx     = SIW'(sp_q - 1'b1);
  assign ret_addr    = ex_ip_q + 1'b1;

  always_comb begin
    wr_en         = 1'b0;
    wr_data       = '0;
    led_wr        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    branch_taken  = 1'b0;
    branch_target = IP_WIDTH'(dest);
    set_stack_err = 1'b0;
    set_illegal   = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_LED: led_wr = 1'b1;
      OP_BLE: branch_taken = a_le_b;
      OP_STO: begin
        wr_en   = 1'b1;
        wr_data = DATA_WIDTH'({src1, src0});
      end
      OP_ADD: begin
        wr_en   = 1'b1;
        wr_data = op_a + op_b;
      end
      OP_JMP: branch_taken = 1'b1;
      OP_SUB: begin
        wr_en   = 1'b1;
        wr_data = op_a - op_b;
      end
      OP_SMUL: begin
        // Low half of the product; kept signed to document the intent.
        wr_en   = 1'b1;
        wr_data = DATA_WIDTH'($signed(op_a) * $signed(op_b));
      end
      OP_SHL: begin
        wr_en   = 1'b1;
        wr_data = op_a << shamt;
      end
      OP_SHR: begin
        wr_en   = 1'b1;
        wr_data = op_a >> shamt;
      end
      OP_CALL: begin
        // A full stack turns CALL into a flagged NOP: no push, no branch.
        if (stack_full) begin
          set_stack_err = 1'b1;
        end else begin
          push         = 1'b1;
          branch_taken = 1'b1;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          set_stack_err = 1'b1;
        end else begin
          pop           = 1'b1;
          branch_taken  = 1'b1;
          branch_target = stack_mem[top_idx];
        end
      end
      default: set_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip_q        <= '0;
      ex_instr_q  <= '0;
      ex_ip_q     <= '0;
      sp_q        <= '0;
      led_q       <= '0;
      stack_err_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      ip_q       <= branch_taken ? branch_target : ip_q + 1'b1;
      // An all-zero word is a NOP: the slot fetched beside a taken branch is squashed.
      ex_instr_q <= branch_taken ? '0 : iInstruction;
      ex_ip_q    <= ip_q;
      if (led_wr) begin
        led_q <= op_a[LED_WIDTH-1:0];
      end
      if (push) begin
        sp_q <= sp_q + 1'b1;
      end else if (pop) begin
        sp_q <= sp_q - 1'b1;
      end
      if (set_stack_err) begin
        stack_err_q <= 1'b1;
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push) begin
      stack_mem[push_idx] <= ret_addr;
    end
  end

  assign oIP         = ip_q;
  assign oLed        = led_q;
  assign oStackError = stack_err_q;
  assign oIllegal    = illegal_q;

endmodule

// File: doc/mini_core_param.md
# mini_core_param

Parametrised successor to the team's 8-LED mini ALU core. Two-stage (fetch / execute) processor executing a 4-bit-opcode, three-address instruction stream from an external instruction memory, with a parametrised register file, signed multiply, shifts, CALL/RET through a bounded return stack, and sticky error reporting. Sits between the instruction ROM and the board LED bank.

## Interface
Parameters:
- DATA_WIDTH, 16: register/ALU width.
- ADDR_WIDTH, 8: register-address and branch-target field width; instruction width is IW = 4 + 3*ADDR_WIDTH (28 by default).
- IP_WIDTH, 16: instruction pointer width.
- STACK_DEPTH, 4: return-stack entries (≥1).
- LED_WIDTH, 8: LED output width (≤ DATA_WIDTH).
- SIGNED_CMP, 0: 1 = BLE compares signed, 0 = unsigned.

Ports:
- Clock  in  1  sole clock, all state on posedge.
- Reset  in  1  synchronous, active-high.
- oIP  out  IP_WIDTH  fetch address to the instruction memory.
- iInstruction  in  IW  instruction at oIP, combinational, same cycle.
- oLed  out  LED_WIDTH  LED register.
- oStackError  out  1  sticky: stack overflow or underflow.
- oIllegal  out  1  sticky: undefined opcode executed.

## Operation
- Field layout: [IW-1:IW-4] opcode, then dest, src1, src0 (ADDR_WIDTH each, src0 lowest). Data operands are A = R[src1], B = R[src0].
- Opcodes: 0 NOP; 1 LED (oLed ← A[LED_WIDTH-1:0]); 2 BLE (branch to dest if A ≤ B); 3 STO (R[dest] ← {src1,src0}, zero-extended/truncated to DATA_WIDTH); 4 ADD (R[dest] ← A+B); 5 JMP (branch to dest); 6 SUB (R[dest] ← A−B); 7 SMUL (R[dest] ← low DATA_WIDTH bits of signed A×B); 8 SHL (R[dest] ← A << B[$clog2(DATA_WIDTH)-1:0]); 9 SHR (logical); A CALL (push EX_IP+1, branch to dest); B RET (pop, branch to popped value); C–F undefined → NOP, set oIllegal.
- All arithmetic is modulo 2^DATA_WIDTH; no carry/overflow flags.
- Branch target: dest zero-extended to IP_WIDTH.
- Return stack: CALL when full → no push, no branch, set oStackError. RET when empty → NOP, set oStackError.
- Register file is not reset; contents are undefined until written.

## Timing
- Fetch: oIP presented; iInstruction and oIP captured into the EX register at posedge.
- Execute: register reads combinational from EX fields; write, LED update, stack push/pop, and IP update at the next posedge.
- Non-branch: oIP increments by 1 per cycle, wraps at 2^IP_WIDTH.
- Taken branch (BLE true, JMP, CALL, RET): the next oIP = target; the instruction fetched during the branch cycle is squashed (loaded into EX as NOP). Branch penalty: 1 cycle.
- Back-to-back dependency: write completes at the posedge that ends EX, so the following instruction reads the new value. No stall, no forwarding.
- Reset (any cycle, including mid-branch or mid-CALL): the next state is oIP=0, EX=NOP, stack empty, oLed=0, oStackError=0, oIllegal=0; no register write or stack change in the reset cycle. Execution resumes at address 0 on the first cycle after Reset deasserts.

## Structure
- Package mini_core_pkg: opcode localparams OP_NOP…OP_RET, field-slice helper constants.
- Sub-module mini_core_regfile: 2^ADDR_WIDTH × DATA_WIDTH, two combinational read ports, one synchronous write port.
- Return stack, decode, and ALU are inline in the top.

## Test plan
- Reset then STO R1←0x0005, STO R2←0x0003, SUB R3←R1−R2, LED R3 → oLed=0x02 on the cycle after LED executes. oIP sequence 0,1,2,3,4.
- Loop: R1=0, R2=1, R3=4; body ADD R1←R1+R2, then BLE back while R1≤R3 → five iterations, final R1=5. Each taken branch shows one squashed slot.
- SMUL 0xFFFE×0x0003 → 0xFFFA. SHL 0x0001 by 17 (masked to 1) → 0x0002. SHR 0x8000 by 15 → 0x0001.
- CALL 0x20 at address 0x05, RET at 0x20 → oIP returns to 0x06. With STACK_DEPTH=4, 5 nested CALLs → 5th not taken, oStackError=1. RET on empty stack → oStackError=1, execution continues sequentially.
- Opcode 0xE → no state change except oIllegal=1, which remains set until Reset.
- Assert Reset in the cycle a JMP is executing → oIP=0 next cycle; oLed, error flags, and stack cleared.
